generation_scheduler: RTL and testbench

//  Sequences one Game-of-Life generation at a time. Drives calc_row/calc_flag into the line buffer
//  and advances on valid_set. Flips the ping-pong BRAM bank select only on a video start-of-frame,
//  so the streamed picture never mixes two generations. Sits between the AXI-Lite regfile controls
//  (run/step) and the line_buffer / mode_selector path, in the out_stream_aclk domain.

---
 rtl/generation_scheduler_if.sv | 40 ++++
 rtl/generation_scheduler.sv | 157 +++++++++++++++
 tb/tb_generation_scheduler.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/generation_scheduler_if.sv
// Control/status bundle between the run/step regfile side and the generation scheduler.
// GEN_SCHED_FRAME_DIV_EN adds the frame_div control field.
interface generation_scheduler_if #(
  parameter int Y_WIDTH   = 10,
  parameter int CNT_WIDTH = 32
);
  logic                 run;
  logic                 step_req;
  logic                 sof;
  logic                 row_valid;
`ifdef GEN_SCHED_FRAME_DIV_EN
  logic [7:0]           frame_div;
`endif
  logic                 calc_flag;
  logic [Y_WIDTH-1:0]   calc_row;
  logic                 bank_sel;
  logic                 busy;
  logic                 gen_done;
  logic [CNT_WIDTH-1:0] gen_count;

`ifdef GEN_SCHED_FRAME_DIV_EN
  modport master (
    output run, step_req, sof, row_valid, frame_div,
    input  calc_flag, calc_row, bank_sel, busy, gen_done, gen_count
  );
  modport slave (
    input  run, step_req, sof, row_valid, frame_div,
    output calc_flag, calc_row, bank_sel, busy, gen_done, gen_count
  );
`else
  modport master (
    output run, step_req, sof, row_valid,
    input  calc_flag, calc_row, bank_sel, busy, gen_done, gen_count
  );
  modport slave (
    input  run, step_req, sof, row_valid,
    output calc_flag, calc_row, bank_sel, busy, gen_done, gen_count
  );
`endif
endinterface

// File: rtl/generation_scheduler.sv
// Sequences one Game-of-Life generation at a time and flips the ping-pong bank only on start-of-frame.
// Optional feature macro: GEN_SCHED_FRAME_DIV_EN (swap at most once per frame_div frames).
module generation_scheduler #(
  parameter int Y_SIZE    = 720,
  parameter int Y_WIDTH   = $clog2(Y_SIZE),
  parameter int CNT_WIDTH = 32
) (
  input  logic                  out_stream_aclk,
  input  logic                  periph_reset,
  generation_scheduler_if.slave ctrl
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CALC      = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic                 calc_flag_r;
  logic                 calc_flag_s;
  logic [Y_WIDTH-1:0]   calc_row_r;
  logic [Y_WIDTH-1:0]   calc_row_s;
  logic                 bank_sel_r;
  logic                 bank_sel_s;
  logic                 busy_r;
  logic                 busy_s;
  logic                 gen_done_r;
  logic                 gen_done_s;
  logic [CNT_WIDTH-1:0] gen_count_r;
  logic [CNT_WIDTH-1:0] gen_count_s;
  logic                 step_pending_r;
  logic                 step_pending_s;
  logic                 last_row_s;
  logic                 frame_ok_s;
  logic                 swap_s;

`ifdef GEN_SCHED_FRAME_DIV_EN
  logic [7:0]           frame_cnt_r;

  // Qualify sof once enough frames have elapsed; a divider of 0 acts as 1.
  always_comb begin
    frame_ok_s = (({1'b0, frame_cnt_r} + 9'd1) >=
                  ((ctrl.frame_div == 8'd0) ? 9'd1 : {1'b0, ctrl.frame_div}));
  end

  // Saturating count of frames seen since the last swap.
  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      frame_cnt_r <= 8'd0;
    end else if (swap_s) begin
      frame_cnt_r <= 8'd0;
    end else if (ctrl.sof && (frame_cnt_r != 8'hFF)) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end
`else
  assign frame_ok_s = 1'b1;
`endif

  assign last_row_s = ctrl.row_valid && (calc_row_r == Y_WIDTH'(Y_SIZE - 1));
  assign swap_s     = (state_r == WAIT_SWAP) && ctrl.sof && frame_ok_s;

  // State and registered outputs.
  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      state_r        <= IDLE;
      calc_flag_r    <= 1'b0;
      calc_row_r     <= {Y_WIDTH{1'b0}};
      bank_sel_r     <= 1'b0;
      busy_r         <= 1'b0;
      gen_done_r     <= 1'b0;
      gen_count_r    <= {CNT_WIDTH{1'b0}};
      step_pending_r <= 1'b0;
    end else begin
      state_r        <= state_nx_s;
      calc_flag_r    <= calc_flag_s;
      calc_row_r     <= calc_row_s;
      bank_sel_r     <= bank_sel_s;
      busy_r         <= busy_s;
      gen_done_r     <= gen_done_s;
      gen_count_r    <= gen_count_s;
      step_pending_r <= step_pending_s;
    end
  end

  // Next-state: a stale step never chains a generation out of WAIT_SWAP.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (ctrl.run || step_pending_r) begin
          state_nx_s = CALC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CALC: begin
        if (last_row_s) begin
          state_nx_s = WAIT_SWAP;
        end else begin
          state_nx_s = CALC;
        end
      end
      WAIT_SWAP: begin
        if (swap_s) begin
          state_nx_s = ctrl.run ? CALC : IDLE;
        end else begin
          state_nx_s = WAIT_SWAP;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    calc_row_s = calc_row_r;
    if (state_r == CALC) begin
      if (last_row_s) begin
        calc_row_s = {Y_WIDTH{1'b0}};
      end else if (ctrl.row_valid) begin
        calc_row_s = calc_row_r + Y_WIDTH'(1);
      end else begin
        calc_row_s = calc_row_r;
      end
    end else begin
      calc_row_s = {Y_WIDTH{1'b0}};
    end

    calc_flag_s = (state_nx_s == CALC);
    busy_s      = (state_nx_s != IDLE);
    gen_done_s  = swap_s;
    bank_sel_s  = swap_s ? ~bank_sel_r : bank_sel_r;
    gen_count_s = swap_s ? (gen_count_r + CNT_WIDTH'(1)) : gen_count_r;

    step_pending_s = step_pending_r;
    if ((state_r == IDLE) && (state_nx_s == CALC)) begin
      step_pending_s = 1'b0;
    end else if (ctrl.step_req && !ctrl.run) begin
      step_pending_s = 1'b1;
    end else begin
      step_pending_s = step_pending_r;
    end
  end

  assign ctrl.calc_flag = calc_flag_r;
  assign ctrl.calc_row  = calc_row_r;
  assign ctrl.bank_sel  = bank_sel_r;
  assign ctrl.busy      = busy_r;
  assign ctrl.gen_done  = gen_done_r;
  assign ctrl.gen_count = gen_count_r;

endmodule

// File: tb/tb_generation_scheduler.sv
// Directed bench for generation_scheduler; bank flips are scoreboarded against gen_done pulses.
module tb_generation_scheduler;
  localparam int Y_SIZE    = 720;
  localparam int Y_WIDTH   = $clog2(Y_SIZE);
  localparam int CNT_WIDTH = 32;

  logic out_stream_aclk = 1'b0;
  logic periph_reset;

  always #5 out_stream_aclk = ~out_stream_aclk;

  generation_scheduler_if #(.Y_WIDTH(Y_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bif ();

  generation_scheduler #(.Y_SIZE(Y_SIZE), .Y_WIDTH(Y_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .out_stream_aclk (out_stream_aclk),
    .periph_reset    (periph_reset),
    .ctrl            (bif)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [CNT_WIDTH:0]   sb_q[$];
  logic                 exp_bank  = 1'b0;
  logic [CNT_WIDTH-1:0] exp_count = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge out_stream_aclk);
      #1;
    end
  endtask

  // Each gen_done pulse must match the oldest expected swap.
  always @(negedge out_stream_aclk) begin
    if (bif.gen_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("gen_done_spurious", 64'(bif.gen_done), 64'd0);
      end else begin
        logic [CNT_WIDTH:0] e;
        e = sb_q.pop_front();
        check("swap_bank_count", 64'({bif.bank_sel, bif.gen_count}), 64'(e));
      end
    end
  end

  task automatic feed_rows(input int nrows, input int gap, input bit sof_on_last, input int mid_sof_row);
    for (int r = 0; r < nrows; r++) begin
      for (int g = 1; g < gap; g++) begin
        bif.sof = (r == mid_sof_row) && (g == 1);
        cycles(1);
        bif.sof = 1'b0;
      end
      check("calc_row", 64'(bif.calc_row), 64'(r));
      check("calc_flag_in_calc", 64'(bif.calc_flag), 64'd1);
      bif.row_valid = 1'b1;
      bif.sof       = sof_on_last && (r == Y_SIZE - 1);
      cycles(1);
      bif.row_valid = 1'b0;
      bif.sof       = 1'b0;
    end
  endtask

  task automatic check_wait_swap();
    check("ws_calc_flag", 64'(bif.calc_flag), 64'd0);
    check("ws_calc_row", 64'(bif.calc_row), 64'd0);
    check("ws_busy", 64'(bif.busy), 64'd1);
    check("ws_bank_held", 64'(bif.bank_sel), 64'(exp_bank));
  endtask

  task automatic do_swap();
    exp_bank  = ~exp_bank;
    exp_count = exp_count + 1;
    sb_q.push_back({exp_bank, exp_count});
    bif.sof = 1'b1;
    cycles(1);
    bif.sof = 1'b0;
    check("bank_sel_after_swap", 64'(bif.bank_sel), 64'(exp_bank));
    check("gen_count_after_swap", 64'(bif.gen_count), 64'(exp_count));
    if (bif.run) begin
      check("restart_calc_flag", 64'(bif.calc_flag), 64'd1);
      check("restart_calc_row", 64'(bif.calc_row), 64'd0);
      check("restart_busy", 64'(bif.busy), 64'd1);
    end else begin
      check("idle_calc_flag", 64'(bif.calc_flag), 64'd0);
      check("idle_busy", 64'(bif.busy), 64'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_calc_flag"}, 64'(bif.calc_flag), 64'd0);
    check({tag, "_calc_row"}, 64'(bif.calc_row), 64'd0);
    check({tag, "_bank_sel"}, 64'(bif.bank_sel), 64'd0);
    check({tag, "_busy"}, 64'(bif.busy), 64'd0);
    check({tag, "_gen_done"}, 64'(bif.gen_done), 64'd0);
    check({tag, "_gen_count"}, 64'(bif.gen_count), 64'd0);
  endtask

  initial begin
    periph_reset  = 1'b1;
    bif.run       = 1'b1;
    bif.step_req  = 1'b0;
    bif.sof       = 1'b0;
    bif.row_valid = 1'b0;
`ifdef GEN_SCHED_FRAME_DIV_EN
    bif.frame_div = 8'd0;
`endif

    // T1: reset held with run=1, then calc_flag one edge after release
    cycles(3);
    check_reset_values("t1_reset");
    periph_reset = 1'b0;
    cycles(1);
    check("t1_calc_flag_rise", 64'(bif.calc_flag), 64'd1);
    check("t1_busy_rise", 64'(bif.busy), 64'd1);
    check("t1_calc_row", 64'(bif.calc_row), 64'd0);
    bif.run      = 1'b0;
    periph_reset = 1'b1;
    cycles(1);
    periph_reset = 1'b0;
    check_reset_values("t1_rereset");

    // T2: single step with rows every cycle, sof 10 cycles after the last row
    bif.step_req = 1'b1;
    cycles(1);
    bif.step_req = 1'b0;
    check("t2_pending_idle", 64'(bif.busy), 64'd0);
    cycles(1);
    check("t2_calc_flag", 64'(bif.calc_flag), 64'd1);
    feed_rows(Y_SIZE, 1, 1'b0, -1);
    check_wait_swap();
    cycles(10);
    check_wait_swap();
    do_swap();
    cycles(1);
    check("t2_gen_done_one_cycle", 64'(bif.gen_done), 64'd0);
    cycles(5);
    check("t2_no_chain", 64'(bif.busy), 64'd0);

    // T3: free run, slow rows, sof pulses in CALC ignored, run dropped in the third generation
    periph_reset = 1'b1;
    cycles(1);
    periph_reset = 1'b0;
    exp_bank  = 1'b0;
    exp_count = '0;
    bif.run = 1'b1;
    cycles(1);
    check("t3_calc_flag", 64'(bif.calc_flag), 64'd1);
    for (int g = 0; g < 3; g++) begin
      if (g == 2) bif.run = 1'b0;
      feed_rows(Y_SIZE, 4, 1'b0, 100);
      check_wait_swap();
      cycles(2000);
      check_wait_swap();
      do_swap();
    end
    check("t3_gen_count", 64'(bif.gen_count), 64'd3);
    check("t3_bank_sel", 64'(bif.bank_sel), 64'd1);

    // T4: sof on the last row does not swap; step_req under run is ignored
    bif.run = 1'b1;
    cycles(1);
    bif.step_req = 1'b1;
    cycles(1);
    bif.step_req = 1'b0;
    feed_rows(Y_SIZE, 1, 1'b1, -1);
    check_wait_swap();
    cycles(3);
    check_wait_swap();
    bif.run = 1'b0;
    do_swap();
    cycles(5);
    check("t4_idle", 64'(bif.busy), 64'd0);
    check("t4_gen_count", 64'(bif.gen_count), 64'd4);

    // T5: reset mid-generation after a swap left bank_sel=1
    bif.run = 1'b1;
    cycles(1);
    feed_rows(Y_SIZE, 1, 1'b0, -1);
    do_swap();
    feed_rows(300, 1, 1'b0, -1);
    check("t5_calc_row_300", 64'(bif.calc_row), 64'd300);
    check("t5_bank_before", 64'(bif.bank_sel), 64'd1);
    periph_reset = 1'b1;
    bif.run      = 1'b0;
    cycles(1);
    periph_reset = 1'b0;
    exp_bank  = 1'b0;
    exp_count = '0;
    check_reset_values("t5_abort");
    cycles(3);
    check("t5_stays_idle", 64'(bif.busy), 64'd0);

`ifdef GEN_SCHED_FRAME_DIV_EN
    // T6: frame divider of 3 then 0
    bif.frame_div = 8'd3;
    bif.run = 1'b1;
    cycles(1);
    feed_rows(Y_SIZE, 1, 1'b0, -1);
    for (int s = 0; s < 2; s++) begin
      bif.sof = 1'b1;
      cycles(1);
      bif.sof = 1'b0;
      cycles(2);
      check_wait_swap();
    end
    do_swap();
    bif.frame_div = 8'd0;
    bif.run = 1'b0;
    feed_rows(Y_SIZE, 1, 1'b0, -1);
    check_wait_swap();
    do_swap();
`endif

    cycles(3);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
